// File: rtl/add_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM state
// encoding and the index-width helper.
package add_seq_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width needed to index n nibbles; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_nibble_seq_cell.sv
// 4-bit ripple-carry adder cell; also exposes the carry into its top bit so
// the caller can derive signed overflow.
module add_nibble_cell
    import add_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    always_comb begin
        logic [NIB_W:0] c;
        c        = '0;
        c[0]     = c_in;
        sum      = '0;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out    = c[NIB_W];
        c_msb_in = c[NIB_W-1];
    end

endmodule

// File: rtl/add_nibble_seq.sv
// Multi-cycle wide adder: one nibble per clock through a single adder cell,
// with valid/ready handshakes on the operand and result sides.
module add_nibble_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned N_NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [NIB_W*N_NIBBLES-1:0]   a,
    input  logic [NIB_W*N_NIBBLES-1:0]   b,
    input  logic                         c_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NIB_W*N_NIBBLES-1:0]   sum,
    output logic                         c_out,
    output logic                         ovf,
    output logic                         busy
);

    localparam int unsigned IW = clog2(N_NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_NIBBLES - 1);

    state_e                              state_q;
    logic [IW-1:0]                       idx_q;
    logic                                carry_q;
    logic [N_NIBBLES-1:0][NIB_W-1:0]     a_q;
    logic [N_NIBBLES-1:0][NIB_W-1:0]     b_q;
    logic [N_NIBBLES-1:0][NIB_W-1:0]     acc_q;
    logic [N_NIBBLES-1:0][NIB_W-1:0]     acc_d;
    logic [N_NIBBLES-1:0][NIB_W-1:0]     sum_q;
    logic                                c_out_q;
    logic                                ovf_q;
    logic                                res_valid_q;
    logic                                busy_q;

    logic [NIB_W-1:0]                    cell_sum;
    logic                                cell_co;
    logic                                cell_cmsb;
    logic                                accept;

    add_nibble_cell u_cell (
        .a        (a_q[idx_q]),
        .b        (b_q[idx_q]),
        .c_in     (carry_q),
        .sum      (cell_sum),
        .c_out    (cell_co),
        .c_msb_in (cell_cmsb)
    );

    assign start_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready);
    assign accept      = start_valid & start_ready;

    // Partial sums live in acc_q; the visible sum is only loaded when the
    // last nibble completes, so it never shows a partial result.
    always_comb begin
        acc_d        = acc_q;
        acc_d[idx_q] = cell_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            a_q         <= a;
            b_q         <= b;
            carry_q     <= c_in;
            acc_q       <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= cell_co;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        sum_q       <= acc_d;
                        c_out_q     <= cell_co;
                        ovf_q       <= cell_cmsb ^ cell_co;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_add_nibble_seq.sv
// Scoreboard bench for add_nibble_seq (N_NIBBLES=4): directed corner cases,
// stall/reset scenarios and randomized back-to-back traffic.
module tb_add_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           t_acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   shown = 0;

    add_nibble_seq #(.N_NIBBLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .c_out       (c_out),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        longint u;
        longint s;
        u = longint'(x) + longint'(y) + longint'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        e.s  = u[W-1:0];
        e.co = u[W];
        e.ov = (s > 32767) || (s < -32768);
        e.t_acc = 0;
        return e;
    endfunction

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output int waits);
        exp_t e;
        waits = 0;
        start_valid = 1'b1;
        a = ta;
        b = tb;
        c_in = tc;
        forever begin
            @(negedge clk);
            if (start_ready) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            chk("start_ready_timeout", 32'd0, 32'd1);
        end else begin
            e = model(ta, tb, tc);
            e.t_acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid) begin
            if (!shown) begin
                shown = 1;
                if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - sb[0].t_acc), 32'(N));
            end
            if (res_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("c_out", 32'(c_out), 32'(e.co));
                    chk("ovf", 32'(ovf), 32'(e.ov));
                end
                shown = 0;
            end
        end
    end

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    initial begin
        int w;
        int viol;
        bit done;

        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({c_out, ovf}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("start_ready_after_rst", 32'(start_ready), 32'd1);

        res_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, w);
        drain(20);
        send(16'hFFFF, 16'h0000, 1'b1, w);
        drain(20);
        send(16'h7FFF, 16'h0001, 1'b0, w);
        drain(20);
        send(16'h8000, 16'h8000, 1'b0, w);
        drain(20);
        send(16'hFFFF, 16'hFFFF, 1'b1, w);
        drain(20);

        // Stalled consumer: result held, no new operands accepted.
        res_ready = 1'b0;
        send(16'h0F0F, 16'h0101, 1'b0, w);
        w = 0;
        while (!res_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stall_valid_seen", 32'(res_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'h1010);
            chk("stall_flags", 32'({c_out, ovf}), 32'd0);
            chk("stall_start_ready", 32'(start_ready), 32'd0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        send(16'h1111, 16'h2222, 1'b0, w);
        chk("same_cycle_accept", 32'(w), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        drain(20);

        // Reset in the middle of a run discards the operation.
        send(16'hAAAA, 16'h5555, 1'b1, w);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_flags", 32'({res_valid, busy, c_out, ovf}), 32'd0);
        void'(sb.pop_back());
        shown = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("start_ready_after_midrst", 32'(start_ready), 32'd1);
        viol = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (res_valid || busy) viol++;
        end
        chk("no_stale_result", 32'(viol), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random consumer stalls.
        done = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), w);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
